// File: rtl/button_event_scheduler.sv
// button_event_scheduler: classifies debounced button presses as short/long events and queues them for a valid/ready consumer
module button_event_scheduler #(
  parameter int N_BTN    = 5,
  parameter int LONG_CYC = 100_000_000,
  parameter int CNT_W    = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_lvl,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_id,
  output logic             evt_long,
  output logic [2:0]       fifo_cnt,
  output logic             ovf,
  input  logic             ovf_clr
);
  logic [N_BTN-1:0] btn_q, long_done, pend, pend_long, ev, ev_long, acc, gnt;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [3:0]       mem [4];
  logic [1:0]       wp, rp;
  logic [2:0]       sel;
  logic             has, push, pop;
  always_comb begin
    ev      = '0;
    ev_long = '0;
    sel     = '0;
    has     = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      ev_long[i] = btn_lvl[i] & btn_q[i] & (cnt[i] == CNT_W'(LONG_CYC - 1));
      ev[i]      = ev_long[i] | (~btn_lvl[i] & btn_q[i] & ~long_done[i]);
    end
    for (int i = N_BTN - 1; i >= 0; i--)
      if (pend[i]) begin
        sel = 3'(i);
        has = 1'b1;
      end
  end
  assign acc       = ev & ~pend;
  assign pop       = evt_valid & evt_ready;
  assign push      = has & ((fifo_cnt != 3'd4) | pop);
  assign gnt       = push ? (N_BTN'(1) << sel) : '0;
  assign evt_valid = fifo_cnt != 3'd0;
  assign evt_id    = evt_valid ? mem[rp][3:1] : 3'd0;
  assign evt_long  = evt_valid & mem[rp][0];
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q     <= '0;
      long_done <= '0;
      pend      <= '0;
      pend_long <= '0;
      wp        <= '0;
      rp        <= '0;
      fifo_cnt  <= '0;
      ovf       <= 1'b0;
      for (int i = 0; i < N_BTN; i++) cnt[i] <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      btn_q <= btn_lvl;
      for (int i = 0; i < N_BTN; i++)
        if (btn_lvl[i] & ~btn_q[i]) begin
          cnt[i]       <= CNT_W'(1);
          long_done[i] <= 1'b0;
        end else if (btn_lvl[i]) begin
          cnt[i]       <= (cnt[i] == CNT_W'(LONG_CYC)) ? cnt[i] : cnt[i] + CNT_W'(1);
          long_done[i] <= long_done[i] | ev_long[i];
        end
      pend      <= (pend & ~gnt) | acc;
      pend_long <= (pend_long & ~acc) | (ev_long & acc);
      ovf       <= (|(ev & pend)) | (ovf & ~ovf_clr);
      if (push) begin
        mem[wp] <= {sel, pend_long[sel]};
        wp      <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
    end
  end
endmodule

// File: tb/tb_button_event_scheduler.sv
// tb_button_event_scheduler: vector table, directed sequences and random run against a queue-based reference model
module tb_button_event_scheduler;
  localparam int LC = 20;
  logic       clk = 1'b0, rst = 1'b1, evt_ready = 1'b1, ovf_clr = 1'b0;
  logic [4:0] btn_lvl = '0;
  logic       evt_valid, evt_long, ovf;
  logic [2:0] evt_id, fifo_cnt;
  int         total = 0, bad = 0;
  button_event_scheduler #(.N_BTN(5), .LONG_CYC(LC), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .btn_lvl(btn_lvl), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_id(evt_id), .evt_long(evt_long), .fifo_cnt(fifo_cnt), .ovf(ovf), .ovf_clr(ovf_clr)
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [2:0] id; logic lg;} ev_t;
  typedef struct {
    logic r; logic [4:0] b; logic rdy; logic clr;
    logic v; logic [2:0] id; logic lg; logic [2:0] cnt; logic o;
  } vec_t;
  ev_t  mq[$];
  int   hl[5];
  bit   prv[5], mp[5], mpl[5];
  bit   movf;
  vec_t tbl[10];
  int   dids[5] = '{1, 2, 3, 4, 1};
  int   dlgs[5] = '{0, 0, 0, 0, 1};
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, a, e, $time);
    end
  endtask
  task automatic model_step();
    bit pop, push, drop;
    int sel;
    bit ev[5], evl[5];
    if (rst) begin
      mq.delete();
      for (int i = 0; i < 5; i++) begin
        hl[i] = 0; prv[i] = 0; mp[i] = 0; mpl[i] = 0;
      end
      movf = 0;
    end else begin
      pop = mq.size() > 0 && evt_ready;
      sel = -1;
      for (int i = 4; i >= 0; i--) if (mp[i]) sel = i;
      push = sel >= 0 && (mq.size() < 4 || pop);
      drop = 0;
      for (int i = 0; i < 5; i++) begin
        ev[i] = 0; evl[i] = 0;
        if (btn_lvl[i] && !prv[i]) hl[i] = 1;
        else if (btn_lvl[i]) begin
          hl[i]++;
          if (hl[i] == LC) begin ev[i] = 1; evl[i] = 1; end
        end else if (prv[i] && hl[i] < LC) ev[i] = 1;
        prv[i] = btn_lvl[i];
        if (ev[i] && mp[i]) drop = 1;
        else if (ev[i]) begin mp[i] = 1; mpl[i] = evl[i]; end
      end
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back({3'(sel), mpl[sel]});
        mp[sel] = 0;
      end
      movf = drop ? 1'b1 : ovf_clr ? 1'b0 : movf;
    end
  endtask
  task automatic tick(input int n);
    logic mv;
    logic [3:0] mh;
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      mv = mq.size() != 0;
      mh = mv ? mq[0] : 4'b0;
      chk("model", {evt_valid, mv ? {evt_id, evt_long} : 4'b0, fifo_cnt, ovf},
          {mv, mh, 3'(mq.size()), movf});
    end
  endtask
  task automatic wait_v(input int lim, output int n);
    tick(1);
    n = 1;
    while (!evt_valid && n < lim) begin
      tick(1);
      n++;
    end
  endtask
  initial begin
    int n, seen;
    tbl[0] = '{1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
    for (int k = 1; k <= 5; k++) tbl[k] = '{1'b0, 5'b00100, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
    tbl[6] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
    tbl[7] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 3'd1, 1'b0};
    tbl[8] = '{1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0};
    tbl[9] = tbl[8];
    for (int k = 0; k < 10; k++) begin
      rst = tbl[k].r; btn_lvl = tbl[k].b; evt_ready = tbl[k].rdy; ovf_clr = tbl[k].clr;
      tick(1);
      chk($sformatf("tbl%0d", k),
          {evt_valid, (tbl[k].v | tbl[k].r) ? {evt_id, evt_long} : 4'b0, fifo_cnt, ovf},
          {tbl[k].v, tbl[k].id, tbl[k].lg, tbl[k].cnt, tbl[k].o});
    end
    btn_lvl = 5'b10000;
    wait_v(40, n);
    chk("long_lat", n, 21);
    chk("long_head", {evt_id, evt_long}, {3'd4, 1'b1});
    tick(9);
    btn_lvl = 5'b0;
    seen = 0;
    repeat (6) begin tick(1); seen += int'(evt_valid); end
    chk("long_rel_quiet", seen, 0);
    btn_lvl = 5'b10000;
    tick(19);
    btn_lvl = 5'b0;
    wait_v(10, n);
    chk("hold19_lat", n, 2);
    chk("hold19_head", {evt_id, evt_long}, {3'd4, 1'b0});
    tick(2);
    btn_lvl = 5'b01011;
    tick(3);
    btn_lvl = 5'b0;
    wait_v(10, n);
    chk("sim_lat", n, 2);
    chk("sim_id0", evt_id, 0);
    tick(1);
    chk("sim_id1", {evt_valid, evt_id}, {1'b1, 3'd1});
    tick(1);
    chk("sim_id3", {evt_valid, evt_id}, {1'b1, 3'd3});
    tick(1);
    chk("sim_empty", evt_valid, 0);
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_lvl = 5'(1 << i);
      tick(2);
      btn_lvl = 5'b0;
      tick(2);
    end
    tick(3);
    chk("full_cnt", fifo_cnt, 4);
    chk("full_head", {evt_valid, evt_id, evt_long, ovf}, {1'b1, 3'd0, 1'b0, 1'b0});
    tick(2);
    chk("full_stable", {evt_valid, evt_id, evt_long}, {1'b1, 3'd0, 1'b0});
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk("pulse_cnt", fifo_cnt, 4);
    chk("pulse_head", evt_id, 1);
    btn_lvl = 5'b00010;
    tick(LC);
    btn_lvl = 5'b0;
    tick(1);
    chk("no_ovf_yet", ovf, 0);
    btn_lvl = 5'b00010;
    tick(2);
    btn_lvl = 5'b0;
    tick(1);
    chk("ovf_set", ovf, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    btn_lvl = 5'b00010;
    tick(2);
    btn_lvl = 5'b0;
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf, 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clr2", ovf, 0);
    evt_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("drain%0d", j), {evt_valid, evt_id, evt_long}, {1'b1, 3'(dids[j]), 1'(dlgs[j])});
      tick(1);
    end
    chk("drain_empty", {evt_valid, fifo_cnt}, 0);
    evt_ready = 1'b0;
    btn_lvl = 5'b00001;
    tick(2);
    btn_lvl = 5'b0;
    tick(1);
    btn_lvl = 5'b00100;
    tick(2);
    btn_lvl = 5'b0;
    tick(2);
    chk("pre_rst_cnt", fifo_cnt, 2);
    btn_lvl = 5'b01000;
    tick(10);
    rst = 1'b1;
    tick(1);
    chk("rst_out", {evt_valid, evt_id, evt_long, fifo_cnt, ovf}, 0);
    rst = 1'b0;
    wait_v(40, n);
    chk("rst_long_lat", n, 21);
    chk("rst_long_head", {evt_id, evt_long, fifo_cnt}, {3'd3, 1'b1, 3'd1});
    btn_lvl = 5'b0;
    evt_ready = 1'b1;
    tick(3);
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 19) == 0) btn_lvl[i] = ~btn_lvl[i];
      evt_ready = (c / 1000) % 2 == 0 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      ovf_clr = $urandom_range(0, 9) == 0;
      rst = $urandom_range(0, 599) == 0;
      tick(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
